// File: rtl/debouncer_multi.sv
// Multi-channel input debouncer.
// Each channel synchronises its raw input, and its output follows the input
// only after the synchronised value has held steady for STABLE_CYCLES clocks.
// Each channel also drives one-cycle rise/fall pulses and a sticky event flag.
// The top level adds a maskable, registered interrupt summary.

// Single debounce lane: synchroniser, stability counter, level/pulse/flag.
module debouncer_chan #(
   parameter int   STABLE_CYCLES = 65536,
   parameter int   SYNC_STAGES   = 2,
   parameter logic RST_LVL       = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   input  logic ev_clr,
   output logic out,
   output logic rise,
   output logic fall,
   output logic ev_pend
);

   localparam int              CW      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   prev;
   logic [CW-1:0]          cnt;

   assign s = sync_q[SYNC_STAGES-1];

   // Synchroniser chain; bit 0 samples the asynchronous pin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sync_q <= {SYNC_STAGES{RST_LVL}};
      else
         sync_q <= {sync_q[SYNC_STAGES-2:0], in};
   end

   // Stability timer: any change restarts it; once saturated, out takes prev.
   // The counter saturates rather than wraps, so a long-stable input never
   // causes a spurious re-qualification.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev <= RST_LVL;
         cnt  <= '0;
         out  <= RST_LVL;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (s != prev) begin
            prev <= s;
            cnt  <= '0;
         end else if (cnt < CNT_MAX) begin
            cnt <= cnt + CW'(1);
         end else if (out != prev) begin
            out  <= prev;
            rise <= prev;
            fall <= ~prev;
         end
      end
   end

   // Sticky event flag; a new edge beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ev_pend <= 1'b0;
      else
         ev_pend <= (ev_pend & ~ev_clr) | rise | fall;
   end

endmodule

// Top: array of independent lanes plus the interrupt summary.
module debouncer_multi #(
   parameter int                  CHANNELS      = 8,
   parameter int                  STABLE_CYCLES = 65536,
   parameter int                  SYNC_STAGES   = 2,
   parameter logic [CHANNELS-1:0] RESET_LEVEL   = {CHANNELS{1'b0}}
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] in,
   output logic [CHANNELS-1:0] out,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   input  logic [CHANNELS-1:0] ev_clr,
   output logic [CHANNELS-1:0] ev_pend,
   input  logic [CHANNELS-1:0] irq_en,
   output logic                irq
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      debouncer_chan #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .SYNC_STAGES   (SYNC_STAGES),
         .RST_LVL       (RESET_LEVEL[i])
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .in      (in[i]),
         .ev_clr  (ev_clr[i]),
         .out     (out[i]),
         .rise    (rise[i]),
         .fall    (fall[i]),
         .ev_pend (ev_pend[i])
      );
   end

   // Registered interrupt summary; lags ev_pend by one clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         irq <= 1'b0;
      else
         irq <= |(ev_pend & irq_en);
   end

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi (4 channels, 16-cycle stability window).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so "tick k" is the k-th rising edge after a stimulus change.
module tb_debouncer_multi;

   localparam int CH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CH-1:0] in;
   logic [CH-1:0] out;
   logic [CH-1:0] rise;
   logic [CH-1:0] fall;
   logic [CH-1:0] ev_clr;
   logic [CH-1:0] ev_pend;
   logic [CH-1:0] irq_en;
   logic          irq;

   int errors = 0;
   int checks = 0;

   debouncer_multi #(
      .CHANNELS      (CH),
      .STABLE_CYCLES (16),
      .SYNC_STAGES   (2),
      .RESET_LEVEL   (4'b0000)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .in      (in),
      .out     (out),
      .rise    (rise),
      .fall    (fall),
      .ev_clr  (ev_clr),
      .ev_pend (ev_pend),
      .irq_en  (irq_en),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running required finished");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in = '0; ev_clr = '0; irq_en = '0;
      tick(); tick();
      checks++; if (out !== 4'h0) begin errors++; $display("FAIL reset_out: got %h required 0", out); end
      checks++; if ((rise | fall) !== 4'h0) begin errors++; $display("FAIL reset_pulses: got rise=%h fall=%h required 0", rise, fall); end
      checks++; if (ev_pend !== 4'h0) begin errors++; $display("FAIL reset_ev_pend: got %h required 0", ev_pend); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b required 0", irq); end
      rst_n = 1'b1;
      repeat (24) tick();
      checks++; if (out !== 4'h0 || ev_pend !== 4'h0) begin errors++; $display("FAIL idle_after_reset: got out=%h ev_pend=%h required 0", out, ev_pend); end
   endtask

   task automatic test_single_rise();
      logic early;
      early = 1'b0;
      in[0] = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         tick();
         if (out !== 4'h0 || rise !== 4'h0) early = 1'b1;
      end
      checks++; if (early) begin errors++; $display("FAIL rise0_early: got out before tick 19 required none"); end
      tick();
      checks++; if (out !== 4'b0001) begin errors++; $display("FAIL rise0_out: got %h required 1", out); end
      checks++; if (rise !== 4'b0001 || fall !== 4'h0) begin errors++; $display("FAIL rise0_pulse: got rise=%h fall=%h required 1/0", rise, fall); end
      tick();
      checks++; if (rise !== 4'h0) begin errors++; $display("FAIL rise0_one_cycle: got %h required 0", rise); end
      checks++; if (ev_pend !== 4'b0001) begin errors++; $display("FAIL rise0_ev_pend: got %h required 1", ev_pend); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rise0_irq_masked: got %b required 0", irq); end
   endtask

   task automatic test_bounce();
      logic glitch;
      glitch = 1'b0;
      for (int p = 0; p < 4; p++) begin
         in[1] = (p % 2 == 0);
         repeat (5) begin
            tick();
            if (rise[1] || fall[1] || out[1]) glitch = 1'b1;
         end
      end
      in[1] = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         tick();
         if (rise[1] || fall[1] || out[1]) glitch = 1'b1;
      end
      checks++; if (glitch) begin errors++; $display("FAIL bounce_intermediate: got pulse/out during bounce required none"); end
      tick();
      checks++; if (out !== 4'b0011 || rise !== 4'b0010) begin errors++; $display("FAIL bounce_settle: got out=%h rise=%h required 3/2", out, rise); end
   endtask

   task automatic test_glitch();
      logic seen;
      seen = 1'b0;
      in[2] = 1'b1;
      repeat (15) begin
         tick();
         if (out[2] || rise[2] || fall[2]) seen = 1'b1;
      end
      in[2] = 1'b0;
      repeat (40) begin
         tick();
         if (out[2] || rise[2] || fall[2]) seen = 1'b1;
      end
      checks++; if (seen) begin errors++; $display("FAIL glitch15: got out/pulse on ch2 required none"); end
      checks++; if (ev_pend[2] !== 1'b0) begin errors++; $display("FAIL glitch15_ev: got %b required 0", ev_pend[2]); end
   endtask

   task automatic test_irq();
      logic early;
      irq_en = 4'b0001;
      tick();
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b required 1", irq); end
      ev_clr = 4'b0001;
      tick();
      checks++; if (ev_pend !== 4'b0010) begin errors++; $display("FAIL ev_clr0: got %h required 2", ev_pend); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_lag: got %b required 1", irq); end
      ev_clr = 4'b0000;
      tick();
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b required 0", irq); end
      // Hold the clear through a falling edge on channel 0: the set must win.
      ev_clr = 4'b0001;
      in[0]  = 1'b0;
      early  = 1'b0;
      for (int k = 1; k <= 18; k++) begin
         tick();
         if (out[0] !== 1'b1 || fall[0] !== 1'b0) early = 1'b1;
      end
      checks++; if (early) begin errors++; $display("FAIL fall0_early: got change before tick 19 required none"); end
      tick();
      checks++; if (out[0] !== 1'b0 || fall[0] !== 1'b1 || rise[0] !== 1'b0) begin errors++; $display("FAIL fall0_pulse: got out=%b fall=%b rise=%b required 0/1/0", out[0], fall[0], rise[0]); end
      checks++; if (ev_pend[0] !== 1'b0) begin errors++; $display("FAIL fall0_ev_before: got %b required 0", ev_pend[0]); end
      tick();
      checks++; if (ev_pend[0] !== 1'b1) begin errors++; $display("FAIL set_beats_clr: got %b required 1", ev_pend[0]); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_before_set: got %b required 0", irq); end
      ev_clr = 4'b0000;
      tick();
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_set: got %b required 1", irq); end
      ev_clr = 4'hF;
      tick();
      ev_clr = 4'h0;
      irq_en = 4'h0;
      tick();
   endtask

   task automatic test_reset_mid();
      logic early;
      in[3] = 1'b1;
      repeat (12) tick();
      rst_n = 1'b0;
      #1;
      checks++; if (out !== 4'h0 || rise !== 4'h0 || fall !== 4'h0) begin errors++; $display("FAIL midreset_out: got out=%h rise=%h fall=%h required 0", out, rise, fall); end
      checks++; if (ev_pend !== 4'h0 || irq !== 1'b0) begin errors++; $display("FAIL midreset_flags: got ev=%h irq=%b required 0", ev_pend, irq); end
      tick(); tick();
      rst_n = 1'b1;
      early = 1'b0;
      for (int k = 1; k <= 18; k++) begin
         tick();
         if (out !== 4'h0 || rise !== 4'h0 || fall !== 4'h0) early = 1'b1;
      end
      checks++; if (early) begin errors++; $display("FAIL midreset_early: got activity before tick 19 required none"); end
      tick();
      checks++; if (out !== 4'b1010 || rise !== 4'b1010) begin errors++; $display("FAIL midreset_follow: got out=%h rise=%h required a/a", out, rise); end
   endtask

   task automatic test_back_to_back();
      logic early;
      in = 4'h0;
      repeat (22) tick();
      ev_clr = 4'hF;
      tick();
      ev_clr = 4'h0;
      irq_en = 4'hF;
      tick(); tick();
      checks++; if (out !== 4'h0 || irq !== 1'b0) begin errors++; $display("FAIL all_idle: got out=%h irq=%b required 0/0", out, irq); end
      in = 4'hF;
      early = 1'b0;
      for (int k = 1; k <= 18; k++) begin
         tick();
         if (out !== 4'h0 || rise !== 4'h0) early = 1'b1;
      end
      checks++; if (early) begin errors++; $display("FAIL all_early: got activity before tick 19 required none"); end
      tick();
      checks++; if (rise !== 4'hF || out !== 4'hF) begin errors++; $display("FAIL all_rise: got rise=%h out=%h required f/f", rise, out); end
      tick();
      checks++; if (ev_pend !== 4'hF || rise !== 4'h0 || irq !== 1'b0) begin errors++; $display("FAIL all_ev: got ev=%h rise=%h irq=%b required f/0/0", ev_pend, rise, irq); end
      tick();
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL all_irq: got %b required 1", irq); end
   endtask

   initial begin
      rst_n = 1'b0; in = '0; ev_clr = '0; irq_en = '0;
      #3;
      test_reset();
      test_single_rise();
      test_bounce();
      test_glitch();
      test_irq();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
